// File: rtl/forward_module.sv
// Serial fixed-point DQN forward pass: 9 inputs -> 5 sigmoid hidden -> 4 linear Q-values,
// followed by a greedy argmax. One shared MAC is sequenced by a small FSM.
module forward_module #(
  parameter int unsigned FRAC = 12,
  parameter int unsigned ACCW = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [143:0] x_flat,
  input  logic [719:0] w2_flat,
  input  logic [79:0]  b2_flat,
  input  logic [319:0] w3_flat,
  input  logic [63:0]  b3_flat,
  output logic         busy,
  output logic         done,
  output logic [79:0]  a2_flat,
  output logic [63:0]  a3_flat,
  output logic [15:0]  maxq,
  output logic [1:0]   act
);

  localparam int unsigned DW = 16;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(32'sd32767);
  localparam logic signed [ACCW-1:0] SAT_MIN = ACCW'(-32'sd32768);

  typedef enum logic [1:0] {S_IDLE, S_L2, S_L3, S_ARG} state_e;

  state_e state_q, state_d;

  logic [143:0]            x_q, x_d;
  logic [79:0]             a2_q, a2_d;
  logic [63:0]             a3_q, a3_d;
  logic [15:0]             maxq_q, maxq_d;
  logic [1:0]              act_q, act_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [2:0]              idx_q, idx_d;
  logic [3:0]              step_q, step_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic signed [DW-1:0]    best_val_q, best_val_d;
  logic [1:0]              best_idx_q, best_idx_d;

  // Operand selection for the shared MAC
  logic [3:0]              sel2;
  logic [2:0]              sel3;
  logic [5:0]              w2_word;
  logic [4:0]              w3_word;
  logic signed [DW-1:0]    mac_w, mac_x, bias;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACCW-1:0]  seed, acc_base, mac_sum, shifted;
  logic signed [DW-1:0]    z;
  logic signed [16:0]      zx;
  logic [16:0]             mag;
  logic [12:0]             y;
  logic [DW-1:0]           sig_out;
  logic signed [DW-1:0]    cur;
  logic                    take;

  always_comb begin
    sel2    = (step_q < 4'd9) ? step_q : 4'd0;
    sel3    = (step_q < 4'd5) ? step_q[2:0] : 3'd0;
    w2_word = 6'(idx_q) * 6'd9 + 6'(sel2);
    w3_word = 5'(idx_q[1:0]) * 5'd5 + 5'(sel3);
    if (state_q == S_L3) begin
      mac_w = w3_flat[{w3_word, 4'b0000} +: DW];
      mac_x = a2_q[{sel3, 4'b0000} +: DW];
      bias  = b3_flat[{idx_q[1:0], 4'b0000} +: DW];
    end else begin
      mac_w = w2_flat[{w2_word, 4'b0000} +: DW];
      mac_x = x_q[{sel2, 4'b0000} +: DW];
      bias  = b2_flat[{idx_q, 4'b0000} +: DW];
    end
    prod     = mac_w * mac_x;
    seed     = ACCW'(bias) <<< FRAC;
    acc_base = (step_q == 4'd0) ? seed : acc_q;
    mac_sum  = acc_base + ACCW'(prod);
  end

  // Finalize: rescale, saturate to 16 bits, and piecewise-linear sigmoid on |z|
  always_comb begin
    shifted = acc_q >>> FRAC;
    if (shifted > SAT_MAX)      z = 16'sh7FFF;
    else if (shifted < SAT_MIN) z = 16'sh8000;
    else                        z = DW'(shifted);
    zx  = 17'(z);
    mag = zx[16] ? 17'(-zx) : 17'(zx);
    if (mag >= 17'd20480)     y = 13'd4096;
    else if (mag >= 17'd9728) y = 13'(mag >> 5) + 13'd3456;
    else if (mag >= 17'd4096) y = 13'(mag >> 3) + 13'd2560;
    else                      y = 13'(mag >> 2) + 13'd2048;
    sig_out = z[15] ? 16'(13'd4096 - y) : 16'(y);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_L2;
      S_L2:   if (idx_q == 3'd4 && step_q == 4'd9) state_d = S_L3;
      S_L3:   if (idx_q == 3'd3 && step_q == 4'd5) state_d = S_ARG;
      S_ARG:  if (idx_q == 3'd3) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d        = x_q;
    a2_d       = a2_q;
    a3_d       = a3_q;
    maxq_d     = maxq_q;
    act_d      = act_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    idx_d      = idx_q;
    step_d     = step_q;
    acc_d      = acc_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cur        = a3_q[{idx_q[1:0], 4'b0000} +: DW];
    take       = (idx_q == 3'd0) || (cur > best_val_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d    = x_flat;
          busy_d = 1'b1;
          idx_d  = 3'd0;
          step_d = 4'd0;
        end
      end
      S_L2: begin
        if (step_q != 4'd9) begin
          acc_d  = mac_sum;
          step_d = step_q + 4'd1;
        end else begin
          a2_d[{idx_q, 4'b0000} +: DW] = sig_out;
          step_d = 4'd0;
          idx_d  = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end
      end
      S_L3: begin
        if (step_q != 4'd5) begin
          acc_d  = mac_sum;
          step_d = step_q + 4'd1;
        end else begin
          a3_d[{idx_q[1:0], 4'b0000} +: DW] = z;
          step_d = 4'd0;
          idx_d  = (idx_q == 3'd3) ? 3'd0 : idx_q + 3'd1;
        end
      end
      S_ARG: begin
        // Strict greater-than keeps the lower index on ties
        if (take) begin
          best_val_d = cur;
          best_idx_d = idx_q[1:0];
        end
        if (idx_q == 3'd3) begin
          maxq_d = take ? cur : best_val_q;
          act_d  = take ? idx_q[1:0] : best_idx_q;
          done_d = 1'b1;
          busy_d = 1'b0;
          idx_d  = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q        <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      maxq_q     <= '0;
      act_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      x_q        <= x_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      maxq_q     <= maxq_d;
      act_q      <= act_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      idx_q      <= idx_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign a2_flat = a2_q;
  assign a3_flat = a3_q;
  assign maxq    = maxq_q;
  assign act     = act_q;

endmodule

// File: tb/tb_forward_module.sv
// Directed bench for forward_module: latency, sigmoid segments, saturation, argmax ties,
// mid-pass reset and back-to-back start handling.
module tb_forward_module;

  logic         clk;
  logic         rst;
  logic         start;
  logic [143:0] x_flat;
  logic [719:0] w2_flat;
  logic [79:0]  b2_flat;
  logic [319:0] w3_flat;
  logic [63:0]  b3_flat;
  logic         busy;
  logic         done;
  logic [79:0]  a2_flat;
  logic [63:0]  a3_flat;
  logic [15:0]  maxq;
  logic [1:0]   act;

  int n_tests;
  int n_fail;

  forward_module #(.FRAC(12), .ACCW(40)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x_flat(x_flat), .w2_flat(w2_flat), .b2_flat(b2_flat),
    .w3_flat(w3_flat), .b3_flat(b3_flat),
    .busy(busy), .done(done), .a2_flat(a2_flat), .a3_flat(a3_flat),
    .maxq(maxq), .act(act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_params();
    x_flat  = '0;
    w2_flat = '0;
    b2_flat = '0;
    w3_flat = '0;
    b3_flat = '0;
  endtask

  // x0 = 1.0, w2[j][0] = 1.0, w3[2][*] = 1.0
  task automatic setup_path();
    clear_params();
    x_flat[15:0] = 16'h1000;
    for (int j = 0; j < 5; j++) w2_flat[16*(j*9) +: 16] = 16'h1000;
    for (int j = 0; j < 5; j++) w3_flat[16*(2*5+j) +: 16] = 16'h1000;
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic do_pass(output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (lat < 200) begin
      lat++;
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
  endtask

  task automatic test_reset();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_tests++; if (a2_flat !== 80'h0) begin n_fail++; $display("FAIL reset_a2 got=%h exp=0", a2_flat); end
    n_tests++; if (a3_flat !== 64'h0) begin n_fail++; $display("FAIL reset_a3 got=%h exp=0", a3_flat); end
    n_tests++; if (maxq !== 16'h0) begin n_fail++; $display("FAIL reset_maxq got=%h exp=0", maxq); end
    n_tests++; if (act !== 2'd0) begin n_fail++; $display("FAIL reset_act got=%0d exp=0", act); end
  endtask

  task automatic test_zero_weights();
    int lat;
    clear_params();
    x_flat = {9{16'h1234}};
    do_pass(lat);
    n_tests++; if (lat !== 78) begin n_fail++; $display("FAIL zero_latency got=%0d exp=78", lat); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_done got=%0b exp=0", busy); end
    n_tests++; if (a2_flat !== {5{16'h0800}}) begin n_fail++; $display("FAIL zero_a2 got=%h exp=%h", a2_flat, {5{16'h0800}}); end
    n_tests++; if (a3_flat !== 64'h0) begin n_fail++; $display("FAIL zero_a3 got=%h exp=0", a3_flat); end
    n_tests++; if (maxq !== 16'h0) begin n_fail++; $display("FAIL zero_maxq got=%h exp=0", maxq); end
    n_tests++; if (act !== 2'd0) begin n_fail++; $display("FAIL zero_act got=%0d exp=0", act); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got=%0b exp=0", done); end
  endtask

  task automatic test_single_path();
    int lat;
    setup_path();
    do_pass(lat);
    n_tests++; if (lat !== 78) begin n_fail++; $display("FAIL path_latency got=%0d exp=78", lat); end
    n_tests++; if (a2_flat !== {5{16'h0C00}}) begin n_fail++; $display("FAIL path_a2 got=%h exp=%h", a2_flat, {5{16'h0C00}}); end
    n_tests++; if (a3_flat !== 64'h0000_3C00_0000_0000) begin n_fail++; $display("FAIL path_a3 got=%h exp=00003c0000000000", a3_flat); end
    n_tests++; if (act !== 2'd2) begin n_fail++; $display("FAIL path_act got=%0d exp=2", act); end
    n_tests++; if (maxq !== 16'h3C00) begin n_fail++; $display("FAIL path_maxq got=%h exp=3c00", maxq); end
  endtask

  task automatic test_saturation();
    int lat;
    clear_params();
    b3_flat[31:16] = 16'h7000;
    for (int j = 0; j < 5; j++) w3_flat[16*(1*5+j) +: 16] = 16'h7FFF;
    do_pass(lat);
    n_tests++; if (a3_flat !== 64'h0000_0000_7FFF_0000) begin n_fail++; $display("FAIL sat_a3 got=%h exp=000000007fff0000", a3_flat); end
    n_tests++; if (act !== 2'd1) begin n_fail++; $display("FAIL sat_act got=%0d exp=1", act); end
    n_tests++; if (maxq !== 16'h7FFF) begin n_fail++; $display("FAIL sat_maxq got=%h exp=7fff", maxq); end
  endtask

  // One bias per neuron to hit both rails, a negative input and each linear segment
  task automatic test_sigmoid();
    int lat;
    clear_params();
    b2_flat = {16'h0400, 16'h3000, 16'hE800, 16'h7FFF, 16'h8000};
    do_pass(lat);
    n_tests++; if (a2_flat !== 80'h0900_0F00_0300_1000_0000) begin n_fail++; $display("FAIL sig_a2 got=%h exp=09000f0003001000_0000", a2_flat); end
    n_tests++; if (a3_flat !== 64'h0) begin n_fail++; $display("FAIL sig_a3 got=%h exp=0", a3_flat); end
  endtask

  task automatic test_argmax_tie();
    int lat;
    clear_params();
    b3_flat = {16'h0100, 16'h0200, 16'h0200, 16'hFF00};
    do_pass(lat);
    n_tests++; if (a3_flat !== 64'h0100_0200_0200_FF00) begin n_fail++; $display("FAIL tie_a3 got=%h exp=010002000200ff00", a3_flat); end
    n_tests++; if (act !== 2'd1) begin n_fail++; $display("FAIL tie_act got=%0d exp=1", act); end
    n_tests++; if (maxq !== 16'h0200) begin n_fail++; $display("FAIL tie_maxq got=%h exp=0200", maxq); end
  endtask

  task automatic test_reset_mid();
    int lat;
    setup_path();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (29) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got=%0b exp=1", busy); end
    rst = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%0b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done got=%0b exp=0", done); end
    n_tests++; if (a2_flat !== 80'h0) begin n_fail++; $display("FAIL mid_a2 got=%h exp=0", a2_flat); end
    n_tests++; if ({a3_flat, maxq, act} !== 82'h0) begin n_fail++; $display("FAIL mid_a3_maxq_act got=%h/%h/%0d exp=0", a3_flat, maxq, act); end
    @(negedge clk); rst = 1'b1;
    do_pass(lat);
    n_tests++; if (lat !== 78) begin n_fail++; $display("FAIL restart_latency got=%0d exp=78", lat); end
    n_tests++; if (a2_flat !== {5{16'h0C00}}) begin n_fail++; $display("FAIL restart_a2 got=%h exp=%h", a2_flat, {5{16'h0C00}}); end
    n_tests++; if (a3_flat !== 64'h0000_3C00_0000_0000) begin n_fail++; $display("FAIL restart_a3 got=%h exp=00003c0000000000", a3_flat); end
    n_tests++; if ({maxq, act} !== {16'h3C00, 2'd2}) begin n_fail++; $display("FAIL restart_maxq_act got=%h/%0d exp=3c00/2", maxq, act); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int first_e;
    int second_e;
    int guard;
    setup_path();
    n_done = 0; first_e = -1; second_e = -1;
    @(negedge clk); start = 1'b1;
    for (int e = 0; e < 200; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) first_e = e;
        if (n_done == 2) second_e = e;
      end
    end
    start = 1'b0;
    n_tests++; if (n_done !== 2) begin n_fail++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
    n_tests++; if (first_e !== 78) begin n_fail++; $display("FAIL b2b_first_done got=%0d exp=78", first_e); end
    n_tests++; if (second_e !== 157) begin n_fail++; $display("FAIL b2b_second_done got=%0d exp=157", second_e); end
    n_tests++; if (a3_flat !== 64'h0000_3C00_0000_0000) begin n_fail++; $display("FAIL b2b_a3 got=%h exp=00003c0000000000", a3_flat); end
    n_tests++; if ({maxq, act} !== {16'h3C00, 2'd2}) begin n_fail++; $display("FAIL b2b_maxq_act got=%h/%0d exp=3c00/2", maxq, act); end
    guard = 0;
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got busy=%0b exp=0", busy); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    start   = 1'b0;
    clear_params();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_zero_weights();
    test_single_path();
    test_saturation();
    test_sigmoid();
    test_argmax_tie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
